onehot_stream_encoder: RTL and testbench

- Sequential encoder that is the counterpart to the team's line decoders: takes an N-line multi-hot input vector and emits the binary index of every set line, one index per handshake, lowest index first.
- Sits between request/interrupt-style line banks and any consumer of encoded indices, such as a downstream decoder or a register-file address port.
- Input and output both use valid/ready handshakes.
- A global enable freezes the block.

---
 rtl/onehot_stream_encoder.sv | 78 +++++++
 tb/tb_onehot_stream_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_stream_encoder.sv
// Sequential multi-hot to binary encoder: emits the index of every set line of an
// accepted vector, lowest first, one index per output handshake.
module onehot_stream_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         out_last,
    output logic         zero_pulse
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic         zero_pulse_q, zero_pulse_d;
    logic [N-1:0] pend_rest;

    function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    // Pending vector with its lowest set bit removed; zero means the current beat is the last.
    assign pend_rest  = pend_q & (pend_q - N'(1));

    assign in_ready   = enable && (state_q == IDLE);
    assign out_valid  = enable && (state_q == SEND);
    assign out        = lowest_index(pend_q);
    assign out_last   = out_valid && (pend_q != '0) && (pend_rest == '0);
    assign zero_pulse = zero_pulse_q;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        zero_pulse_d = 1'b0;
        if (in_valid && in_ready) begin
            if (in != '0) begin
                pend_d  = in;
                state_d = SEND;
            end else begin
                zero_pulse_d = 1'b1;
            end
        end
        if (out_valid && out_ready) begin
            pend_d = pend_rest;
            if (pend_rest == '0) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            zero_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            zero_pulse_q <= zero_pulse_d;
        end
    end

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Scoreboard bench for onehot_stream_encoder: directed scenarios followed by
// randomized vectors, enable and back-pressure.
module tb_onehot_stream_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_last;
    logic         zero_pulse;

    int compared;
    int mismatched;
    int cyc;
    bit rnd_mode;

    int exp_idx_q[$];
    bit exp_last_q[$];
    int exp_zero_q[$];

    onehot_stream_encoder #(.N(N), .W(W)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in(din),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .out_last(out_last),
        .zero_pulse(zero_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: list every set line in ascending order; the final one is last.
    task automatic model_push(input logic [N-1:0] v);
        int total;
        int seen;
        total = $countones(v);
        if (total == 0) begin
            exp_zero_q.push_back(cyc + 1);
        end else begin
            seen = 0;
            for (int i = 0; i < N; i++) begin
                if (v[i]) begin
                    seen++;
                    exp_idx_q.push_back(i);
                    exp_last_q.push_back(seen == total);
                end
            end
        end
    endtask

    task automatic flush_model();
        exp_idx_q.delete();
        exp_last_q.delete();
        exp_zero_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            enable    = ($urandom % 8) != 0;
            out_ready = ($urandom % 4) != 0;
        end
        #1;
    endtask

    task automatic send(input logic [N-1:0] v);
        int waited;
        waited = 0;
        while (!in_ready && waited < 500) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            din      = v;
            model_push(v);
            tick();
            in_valid = 1'b0;
            din      = N'($urandom);
        end
    endtask

    // Monitor: every presented beat must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            while (exp_zero_q.size() > 0 && exp_zero_q[0] < cyc) void'(exp_zero_q.pop_front());
            if (exp_zero_q.size() > 0 && exp_zero_q[0] == cyc) begin
                void'(exp_zero_q.pop_front());
                chk("zero_pulse", int'(zero_pulse), 1);
            end else begin
                chk("zero_pulse", int'(zero_pulse), 0);
            end
            if (!enable) begin
                chk("frozen_out_valid", int'(out_valid), 0);
                chk("frozen_in_ready", int'(in_ready), 0);
            end
            if (out_valid) begin
                if (exp_idx_q.size() == 0) begin
                    chk("unexpected_beat_out", int'(out), -1);
                end else begin
                    chk("out_index", int'(out), exp_idx_q[0]);
                    chk("out_last", int'(out_last), int'(exp_last_q[0]));
                    if (out_ready) begin
                        void'(exp_idx_q.pop_front());
                        void'(exp_last_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int drain;
        logic [N-1:0] v;
        compared   = 0;
        mismatched = 0;
        rnd_mode   = 1'b0;
        reset      = 1'b1;
        enable     = 1'b1;
        in_valid   = 1'b0;
        din        = '0;
        out_ready  = 1'b1;

        // 1: reset state
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_zero_pulse", int'(zero_pulse), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        reset = 1'b0;
        tick();

        // 2: three-beat vector at full throughput
        send(8'b0010_0101);
        chk("t2_first_valid", int'(out_valid), 1);
        chk("t2_first_out", int'(out), 0);
        chk("t2_in_ready_busy", int'(in_ready), 0);
        tick();
        tick();
        chk("t2_last_out", int'(out), 5);
        chk("t2_last_flag", int'(out_last), 1);
        tick();
        chk("t2_in_ready_back", int'(in_ready), 1);
        chk("t2_out_valid_done", int'(out_valid), 0);
        chk("t2_drained", exp_idx_q.size(), 0);

        // 3: back-pressure, and input ignored while sending
        out_ready = 1'b0;
        send(8'b1000_0010);
        in_valid = 1'b1;
        din      = 8'hAA;
        chk("t3_in_ready_send", int'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", int'(out_valid), 1);
            chk("t3_hold_out", int'(out), 1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_second_out", int'(out), 7);
        chk("t3_second_last", int'(out_last), 1);
        tick();
        chk("t3_in_ready_back", int'(in_ready), 1);
        chk("t3_drained", exp_idx_q.size(), 0);

        // 4: zero vector
        send(8'h00);
        chk("t4_zero_pulse", int'(zero_pulse), 1);
        chk("t4_out_valid", int'(out_valid), 0);
        chk("t4_in_ready", int'(in_ready), 1);
        tick();
        chk("t4_zero_pulse_clear", int'(zero_pulse), 0);

        // 5: all-ones with a freeze after the third handshake
        send(8'hFF);
        tick();
        tick();
        tick();
        enable = 1'b0;
        #1;
        chk("t5_frozen_valid", int'(out_valid), 0);
        chk("t5_frozen_ready", int'(in_ready), 0);
        for (int i = 0; i < 4; i++) tick();
        enable = 1'b1;
        #1;
        chk("t5_resume_valid", int'(out_valid), 1);
        chk("t5_resume_out", int'(out), 3);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_in_ready_back", int'(in_ready), 1);
        chk("t5_drained", exp_idx_q.size(), 0);

        // 6: reset mid-vector discards the rest
        send(8'b0101_0000);
        chk("t6_first_out", int'(out), 4);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        flush_model();
        chk("t6_after_rst_valid", int'(out_valid), 0);
        chk("t6_after_rst_ready", int'(in_ready), 1);
        chk("t6_after_rst_out", int'(out), 0);
        tick();
        chk("t6_still_idle", int'(out_valid), 0);

        // Randomized traffic
        rnd_mode = 1'b1;
        for (int n = 0; n < 80; n++) begin
            case ($urandom % 6)
                0:       v = '0;
                1:       v = '1;
                2:       v = N'(1) << ($urandom % N);
                default: v = N'($urandom);
            endcase
            send(v);
            if (($urandom % 3) == 0) tick();
        end
        rnd_mode  = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        drain     = 0;
        while ((exp_idx_q.size() > 0 || !in_ready) && drain < 100) begin
            tick();
            drain++;
        end
        chk("final_drained", exp_idx_q.size(), 0);
        chk("final_in_ready", int'(in_ready), 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
